// File: rtl/logic_slice_sequencer.sv
// logic_slice_sequencer: time-shares one SLICE-bit logic slice across the
// WIDTH/SLICE nibbles of an operand pair. The result is published with a
// one-cycle done pulse.
// Optional feature macro: LOGIC_SEQ_ZERO_FLAG_EN adds a registered zero flag
// output that is accumulated per slice.
module logic_slice_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
   output logic [WIDTH-1:0] result,
   output logic             zero
`else
   output logic [WIDTH-1:0] result
`endif
);

   localparam int unsigned NSLICES = WIDTH / SLICE;
   localparam int unsigned CW      = $clog2(NSLICES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_next;
   logic [CW-1:0]     counter;
   logic [WIDTH-1:0]  a_lat, b_lat, shadow, shadow_next;
   logic [1:0]        op_lat;
   logic [SLICE-1:0]  slice_a, slice_b, slice_out;
   int unsigned       base;
   logic              accept, last;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
   logic              nz;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; DONE accepts a new start exactly like IDLE
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (counter == CW'(NSLICES - 1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shared slice: select the current nibble and apply the latched opcode
   always_comb begin
      base    = 32'(counter) * SLICE;
      slice_a = a_lat[base +: SLICE];
      slice_b = b_lat[base +: SLICE];
      case (op_lat)
         2'b00:   slice_out = slice_a & slice_b;
         2'b01:   slice_out = slice_a | slice_b;
         2'b10:   slice_out = slice_a ^ slice_b;
         default: slice_out = ~(slice_a | slice_b);
      endcase
      shadow_next = shadow;
      if (state == RUN) shadow_next[base +: SLICE] = slice_out;
   end

   // Datapath and registered outputs; result includes the final slice on DONE entry
   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         counter <= '0;
         shadow  <= '0;
         a_lat   <= '0;
         b_lat   <= '0;
         op_lat  <= '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
         nz      <= 1'b0;
         zero    <= 1'b0;
`endif
      end else begin
         busy <= (state_next == RUN);
         done <= (state_next == DONE);
         if (accept) begin
            a_lat   <= a;
            b_lat   <= b;
            op_lat  <= op;
            counter <= '0;
            shadow  <= '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            nz      <= 1'b0;
`endif
         end else if (state == RUN) begin
            shadow <= shadow_next;
            if (!last) counter <= counter + CW'(1);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            nz     <= nz | (|slice_out);
`endif
         end
         if (last) begin
            result <= shadow_next;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            zero   <= ~(nz | (|slice_out));
`endif
         end
      end
   end

endmodule

// File: tb/tb_logic_slice_sequencer.sv
// Directed self-checking bench for logic_slice_sequencer with a result scoreboard.
module tb_logic_slice_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
   logic        zero;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb[$];
   logic [31:0] last_res = '0;

   logic_slice_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      .result (result),
      .zero   (zero)
`else
      .result (result)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x ^ y;
         default: return ~(x | y);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start for one edge and record the expected result
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      sb.push_back(model(o, x, y));
      tick();
      start = 1'b0;
   endtask

   // Check the 8 RUN cycles; optionally inject an ignored start at cycle inj
   task automatic run_phase(input int inj);
      for (int k = 0; k < 8; k++) begin
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_done", 32'(done), 32'd0);
         chk("run_result_hold", result, last_res);
         if (k == inj) begin
            start = 1'b1; op = 2'b11; a = 32'h1234_5678; b = 32'h0F0F_0F0F;
         end else if (k == inj + 1) begin
            start = 1'b0; op = 2'b01; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
         end
         tick();
      end
      start = 1'b0;
   endtask

   // Check the DONE cycle against the scoreboard head
   task automatic check_done();
      logic [31:0] exp;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
      end else begin
         exp = sb.pop_front();
         chk("result", result, exp);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
         chk("zero", 32'(zero), 32'(exp == 32'h0));
`endif
         last_res = exp;
      end
   endtask

   task automatic idle_check(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd0);
         chk({tag, "_done"}, 32'(done), 32'd0);
         chk({tag, "_result"}, result, last_res);
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      // Reset state and idle behaviour
      idle_check(5, "reset_idle");

      // AND
      issue(2'b00, 32'hF0F0_1234, 32'hFF00_FFFF);
      run_phase(-2);
      check_done();
      tick();
      idle_check(2, "after_and");

      // Back-to-back OR then NOR (start held in DONE)
      issue(2'b01, 32'h0000_00F0, 32'h0000_000F);
      run_phase(-2);
      check_done();
      start = 1'b1; op = 2'b11; a = 32'h0; b = 32'h0;
      sb.push_back(model(2'b11, 32'h0, 32'h0));
      tick();
      start = 1'b0;
      run_phase(-2);
      check_done();
      tick();
      idle_check(2, "after_b2b");

      // XOR giving zero, then nonzero
      issue(2'b10, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
      run_phase(-2);
      check_done();
      tick();
      issue(2'b10, 32'h0000_0001, 32'h0000_0000);
      run_phase(-2);
      check_done();
      tick();

      // Start during RUN ignored, operand changes ignored
      issue(2'b00, 32'h1357_9BDF, 32'hFFFF_0F0F);
      run_phase(2);
      check_done();
      tick();
      idle_check(10, "no_extra_done");

      // Reset aborts in RUN cycle 4
      issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0000);
      for (int k = 0; k < 3; k++) begin
         chk("abort_run_busy", 32'(busy), 32'd1);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(sb.pop_back());
      last_res = '0;
      idle_check(10, "abort");

      // Normal operation after abort
      issue(2'b11, 32'h0F0F_0000, 32'h00F0_0001);
      run_phase(-2);
      check_done();
      tick();
      idle_check(2, "final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
